seq_divider: RTL
================

Name: seq_divider

Overview:
- Sequential signed restoring divider, WIDTH iterations per operation.
- Sits beside the Booth multiplier datapath and shares its operand/result conventions.
- Accepts a start pulse with dividend/divisor and produces quotient and remainder.
- Emits a one-cycle result-valid strobe that drives a downstream result-register enable directly.

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement, WIDTH >= 4).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state and outputs.
- start  input  1  operation request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  signed dividend; captured on the accepting edge.
- divisor  input  WIDTH  signed divisor; captured on the accepting edge.
- busy  output  1  high from the cycle after acceptance through the FIX cycle.
- valid  output  1  one-cycle pulse; quotient/remainder/div_by_zero are valid this cycle and after.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; its sign follows the dividend.
- div_by_zero  output  1  set with valid when the captured divisor was 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; iteration counter = 0.
  - busy, valid, quotient, remainder and div_by_zero all = 0.
  - Internal registers cleared. An in-flight operation is discarded with no valid pulse.
- States and transitions:
  - IDLE -> CALC when start=1.
  - CALC -> CALC while count != 0.
  - CALC -> FIX when count == 0.
  - FIX -> DONE unconditionally.
  - DONE -> CALC if start=1, else IDLE.
  - start is ignored in CALC and FIX; no queueing, no error flag.
- Accepting edge:
  - Capture sign_q = dividend[MSB] ^ divisor[MSB], sign_r = dividend[MSB], dz = (divisor == 0).
  - Capture the magnitudes |dividend| and |divisor| as WIDTH-bit unsigned values; |most-negative| = 2^(WIDTH-1) is representable.
  - Partial remainder (WIDTH+1 bits) = 0; count = WIDTH-1.
- CALC, one restoring step per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial = partial remainder - divisor magnitude.
  - If trial is non-negative: partial remainder = trial and quotient LSB = 1; otherwise quotient LSB = 0.
  - count decrements each cycle. Exactly WIDTH CALC cycles run.
- FIX (registers the outputs):
  - quotient = sign_q ? -q_mag : q_mag (WIDTH-bit wrap); remainder = sign_r ? -r_mag : r_mag.
  - If dz: quotient = all ones, remainder = original dividend, div_by_zero = 1. CALC still runs; constant latency.
  - Otherwise div_by_zero = 0.
- DONE: valid = 1 for exactly this one cycle; busy = 0.
- Latency:
  - Acceptance edge k: busy rises after edge k.
  - valid is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles after acceptance.
- Output hold: quotient, remainder and div_by_zero hold their values until the next FIX or reset. They are not cleared by a new start.
- Overflow: most-negative / -1 gives quotient = most-negative (wrap) and remainder = 0, with no flag.
- Back-to-back: start high in the DONE cycle is accepted; the next valid comes WIDTH+2 cycles later with no bubble cycle in IDLE.
- Operand changes after acceptance have no effect on the current operation.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, FIX, DONE}.
  - A function abs_w (two's-complement magnitude).
  - A function neg_cond (conditional negate).
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, incoming bit, divisor magnitude.
  - Outputs: next partial remainder, quotient bit.
- Top level holds the FSM, counter and registers.

Test Plan:
- 100 / 7, start pulse -> valid exactly 18 cycles later (WIDTH=16); quotient=14, remainder=2, div_by_zero=0; busy high for 17 cycles.
- -100 / 7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2); 100 / -7 -> quotient=0xFFF2, remainder=2.
- 7 / 0 -> valid after 18 cycles; quotient=0xFFFF, remainder=7, div_by_zero=1. A following 9/3 clears div_by_zero, giving quotient=3, remainder=0.
- -32768 / -1 -> quotient=0x8000, remainder=0. Then 0x7FFF / 1 -> quotient=0x7FFF, remainder=0.
- start re-pulsed with 50/5 during CALC -> ignored; first result 100/7 is delivered unchanged. start held in the DONE cycle with 50/5 -> accepted, quotient=10, remainder=0 after 18 more cycles.
- reset low mid-CALC (cycle 5) -> all outputs 0 asynchronously, no valid pulse. After release, a new 100/7 completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and two's-complement helpers for the sequential signed divider.
package div_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  // Callers sign-extend into MAX_W bits and truncate the result back down.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v);
    return v[MAX_W-1] ? -v : v;
  endfunction

  function automatic logic [MAX_W-1:0] neg_cond(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] ext;
  logic [WIDTH+1:0] trial;

  always_comb begin
    ext      = {rem, in_bit};
    trial    = ext - {2'b00, dmag};
    q_bit    = ~trial[WIDTH+1];
    rem_next = q_bit ? trial[WIDTH:0] : ext[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: WIDTH CALC cycles, one FIX cycle, one-cycle valid.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_t       state, state_n;
  logic             accept;
  logic [WIDTH:0]   pr, pr_n;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] dvd_orig;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic             sign_q, sign_r, dz;
  logic             qbit;
  logic [CW-1:0]    count;

  always_comb begin
    dvd_mag = WIDTH'(abs_w({{(MAX_W-WIDTH){dividend[WIDTH-1]}}, dividend}));
    dsr_mag = WIDTH'(abs_w({{(MAX_W-WIDTH){divisor[WIDTH-1]}}, divisor}));
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (pr),
    .in_bit   (qr[WIDTH-1]),
    .dmag     (dmag),
    .rem_next (pr_n),
    .q_bit    (qbit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_n = CALC;
      end
      CALC: if (count == '0) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = CALC;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // qr starts as the dividend magnitude and is replaced by quotient bits from the LSB up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pr       <= '0;
      qr       <= '0;
      dmag     <= '0;
      dvd_orig <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dz       <= 1'b0;
      count    <= '0;
    end else if (accept) begin
      pr       <= '0;
      qr       <= dvd_mag;
      dmag     <= dsr_mag;
      dvd_orig <= dividend;
      sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r   <= dividend[WIDTH-1];
      dz       <= (divisor == '0);
      count    <= CW'(WIDTH-1);
    end else if (state == CALC) begin
      pr <= pr_n;
      qr <= {qr[WIDTH-2:0], qbit};
      if (count != '0) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == FIX) begin
      quotient    <= dz ? '1 : WIDTH'(neg_cond(MAX_W'(qr), sign_q));
      remainder   <= dz ? dvd_orig : WIDTH'(neg_cond(MAX_W'(pr[WIDTH-1:0]), sign_r));
      div_by_zero <= dz;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      busy  <= (state_n == CALC) || (state_n == FIX);
      valid <= (state_n == DONE);
    end
  end

endmodule
